capture_readout_ctrl: RTL and testbench
=======================================

# capture_readout_ctrl

Sequencer for the ADC capture store. It arms on command and fires the store's write strobe on a qualified trigger edge. Once the store reports full, it drains the store byte by byte and frames the bytes as header, payload and 16-bit count into a byte-wide valid/ready transmit stream. It runs entirely in the store's read-clock domain, between the command decoder and the host transmit interface.

## Interface
- HEADER_BYTE, 8'hA5: first byte of every frame.
- TRIGGER_RISING, 1: 1 = rising-edge trigger, 0 = falling.
- HOLDOFF_CYCLES, 16: cycles after arm during which triggers are ignored (range 0..65535).
- VALID_TIMEOUT, 8: max cycles from StorageReadEnable to StorageDataValid.

Ports:
- ReadClock, in, 1: single clock.
- Reset, in, 1: synchronous, active-high.
- ArmCmd, in, 1: one-cycle pulse; arm a capture.
- AbortCmd, in, 1: one-cycle pulse; abort the current frame.
- ForceTrigger, in, 1: one-cycle pulse; trigger regardless of TriggerIn (holdoff still applies).
- TriggerIn, in, 1: trigger level, already synchronized to ReadClock.
- StorageState, in, 2: store state; 00 ready, 01 storing, 10 sending.
- StorageDataReady, in, 1: store holds unread bytes.
- StorageDataValid, in, 1: StorageData valid this cycle.
- StorageData, in, 8: byte from store.
- WriteStrobe, out, 1: capture start level to store.
- StorageReadEnable, out, 1: one-cycle byte read request.
- TxData, out, 8: transmit byte.
- TxValid, out, 1: TxData valid.
- TxReady, in, 1: sink accepts when TxValid && TxReady.
- Busy, out, 1: state != IDLE.
- Error, out, 1: sticky timeout flag, cleared by ArmCmd or Reset.
- CtrlState, out, 4: current state encoding.

## Operation
- States and encodings: IDLE 0, ARMED 1, STROBE 2, CAPTURE 3, HEADER 4, READ 5, WAIT_VALID 6, SEND 7, TRAILER_HI 8, TRAILER_LO 9.
- IDLE:
  - ArmCmd goes to ARMED.
  - Loading ArmCmd clears the holdoff counter, byte count, Error and the abort flag.
- ARMED:
  - Holdoff counter increments, saturating at HOLDOFF_CYCLES.
  - A trigger is an edge on registered TriggerIn of the selected polarity, or ForceTrigger.
  - A trigger is accepted only if holdoff has expired and StorageState==00. A trigger seen otherwise is dropped, not queued.
  - On accepted trigger, go to STROBE.
- STROBE:
  - WriteStrobe=1.
  - On StorageState==01, go to CAPTURE with WriteStrobe=0.
  - After 4 cycles without StorageState==01, set Error and return to ARMED.
- CAPTURE: on StorageState==10, go to HEADER.
- HEADER: TxData=HEADER_BYTE, TxValid=1. On accept, go to READ.
- READ:
  - If StorageDataReady, pulse StorageReadEnable for one cycle and go to WAIT_VALID.
  - Else if StorageState==00, go to TRAILER_HI.
- WAIT_VALID:
  - On StorageDataValid, latch StorageData into TxData, go to SEND.
  - After VALID_TIMEOUT cycles without StorageDataValid, set Error and return to READ.
- SEND:
  - TxValid=1, held with TxData stable until TxReady.
  - On accept, byte count +1 (saturating 16'hFFFF), return to READ.
- TRAILER_HI / TRAILER_LO: send count[15:8], then count[7:0]. Go to IDLE after the LO accept.
- Abort:
  - In ARMED or STROBE: go to IDLE next cycle, WriteStrobe=0.
  - In CAPTURE..SEND: set the abort flag. The store is still fully drained via StorageReadEnable.
  - While the abort flag is set, HEADER, SEND and trailers are skipped with TxValid=0, and the controller goes to IDLE when the store is empty.
- ArmCmd outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE, CtrlState 0.
  - WriteStrobe 0, StorageReadEnable 0, TxValid 0, TxData 8'h00.
  - Busy 0, Error 0, count 0.
- ArmCmd at cycle N: ARMED and Busy=1 at N+1.
- With HOLDOFF_CYCLES=0, a trigger edge is accepted at N+1.
- Trigger edge sampled at cycle T: WriteStrobe=1 from T+1.
- StorageReadEnable is asserted at most once per byte. No second read is issued until the previous byte has been accepted by the sink or discarded.
- TxValid must not deassert before acceptance, and TxData must not change while TxValid && !TxReady.
- Simultaneous events:
  - Trigger and AbortCmd in the same cycle: abort wins.
  - StorageDataValid on the timeout cycle: data wins, no Error.
- Reset mid-frame: IDLE next cycle, all outputs return to reset values. The store is reset by the same Reset.

## Structure
- Shared package `capture_pkg` holds:
  - state enum and encodings;
  - store state constants (READY 2'b00, STORING 2'b01, SENDING 2'b10);
  - default header byte.
- One natural sub-module: `trigger_qualifier`, covering the TriggerIn edge register, polarity select, ForceTrigger OR and holdoff counter. Its output is a one-cycle accepted-trigger pulse.
- Everything else is a single FSM plus the count, timeout and holdoff counters.

## Test plan
- Normal frame: Arm, holdoff expires, rising edge, store model goes 01 then 10 with 4 bytes 11,22,33,44, TxReady=1. Required stream: A5 11 22 33 44 00 04, then IDLE.
- Backpressure: same frame with TxReady toggled every other cycle. Bytes are identical, TxData stays stable while stalled, and exactly 4 StorageReadEnable pulses occur.
- Holdoff: HOLDOFF_CYCLES=16, trigger edge 5 cycles after Arm. WriteStrobe stays 0 and state remains ARMED. A ForceTrigger 20 cycles after Arm produces WriteStrobe=1 on the following cycle.
- Abort during CAPTURE with 3 bytes stored: exactly 3 reads, TxValid never asserted, ends in IDLE, Error=0.
- Timeout: store withholds StorageDataValid for 8 cycles. Error=1, state returns to READ, and Error stays 1 until the next ArmCmd.
- Reset asserted in SEND with TxValid=1: on the next cycle TxValid=0, Busy=0, CtrlState=0.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the ADC capture readout sequencer.
//
// Contents:
//   ctrl_state_e       - controller state encoding, also exported on CtrlState
//   Store* constants   - encodings of the capture store's StorageState bus
//   DefaultHeaderByte  - first byte of every transmitted frame
//   StrobeAckCycles    - cycles WriteStrobe is held waiting for the store to start
//   is_drain_state()   - states in which an abort is deferred until the store is drained
package capture_pkg;

   typedef enum logic [3:0] {
      StIdle      = 4'd0,
      StArmed     = 4'd1,
      StStrobe    = 4'd2,
      StCapture   = 4'd3,
      StHeader    = 4'd4,
      StRead      = 4'd5,
      StWaitValid = 4'd6,
      StSend      = 4'd7,
      StTrailerHi = 4'd8,
      StTrailerLo = 4'd9
   } ctrl_state_e;

   localparam logic [1:0] StoreReady   = 2'b00;
   localparam logic [1:0] StoreStoring = 2'b01;
   localparam logic [1:0] StoreSending = 2'b10;

   localparam logic [7:0] DefaultHeaderByte = 8'hA5;

   localparam int unsigned StrobeAckCycles = 4;

   // Abort in these states cannot simply drop back to idle: the store already holds
   // (or is filling with) a capture that must be read out to leave it empty.
   function automatic logic is_drain_state(input ctrl_state_e s);
      return (s >= StCapture) && (s <= StSend);
   endfunction

endpackage

// File: rtl/trigger_qualifier.sv
// Trigger qualification for the capture sequencer.
//
// Registers the (already synchronised) trigger level, detects an edge of the
// selected polarity, ORs in the manual force, and gates the result with a
// saturating holdoff counter and the store-ready condition.
//
// Ports:
//   clk            - read clock
//   rst            - synchronous active-high reset
//   clear          - restart the holdoff window (capture being armed)
//   enable         - controller is armed; holdoff counts and triggers may pass
//   abort          - abort request this cycle; suppresses the trigger
//   trigger_in     - trigger level
//   force_trigger  - one-cycle manual trigger, still subject to holdoff
//   store_state    - capture store state bus
//   trigger_accept - one-cycle pulse: trigger accepted this cycle
module trigger_qualifier
   import capture_pkg::*;
#(
   parameter bit          TRIGGER_RISING = 1'b1,
   parameter int unsigned HOLDOFF_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       enable,
   input  logic       abort,
   input  logic       trigger_in,
   input  logic       force_trigger,
   input  logic [1:0] store_state,
   output logic       trigger_accept
);

   localparam logic [15:0] HoldoffLast = 16'(HOLDOFF_CYCLES);

   logic        trigger_q;
   logic [15:0] holdoff_q, holdoff_d;
   logic        edge_seen;
   logic        holdoff_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         trigger_q <= 1'b0;
         holdoff_q <= '0;
      end else begin
         trigger_q <= trigger_in;
         holdoff_q <= holdoff_d;
      end
   end

   // Counts only while armed and parks at the limit, so "expired" is a plain
   // equality compare; a limit of zero is expired from the first armed cycle.
   always_comb begin
      holdoff_d = holdoff_q;
      if (clear) begin
         holdoff_d = '0;
      end else if (enable && (holdoff_q != HoldoffLast)) begin
         holdoff_d = holdoff_q + 16'd1;
      end
   end

   always_comb begin
      if (TRIGGER_RISING) begin
         edge_seen = trigger_in & ~trigger_q;
      end else begin
         edge_seen = ~trigger_in & trigger_q;
      end
      holdoff_done = (holdoff_q == HoldoffLast);
      // Triggers failing any qualifier are dropped outright, never remembered.
      trigger_accept = enable & holdoff_done & ~abort & (store_state == StoreReady) &
                       (edge_seen | force_trigger);
   end

endmodule

// File: rtl/capture_readout_ctrl.sv
// Capture readout sequencer.
//
// Arms on command, fires the store's WriteStrobe on a qualified trigger, waits
// for the capture to complete, then drains the store one byte at a time and
// frames the data on a byte-wide valid/ready stream:
//   HEADER_BYTE, payload bytes..., count[15:8], count[7:0]
// An abort after capture has started still drains the store but sends nothing.
//
// Ports:
//   ReadClock         - single clock (store read-clock domain)
//   Reset             - synchronous active-high reset
//   ArmCmd            - pulse; arm a capture (ignored unless idle)
//   AbortCmd          - pulse; abort the current frame
//   ForceTrigger      - pulse; trigger without an edge (holdoff still applies)
//   TriggerIn         - synchronised trigger level
//   StorageState      - store state: 00 ready, 01 storing, 10 sending
//   StorageDataReady  - store holds unread bytes
//   StorageDataValid  - StorageData valid this cycle
//   StorageData       - byte from store
//   WriteStrobe       - capture start level to store
//   StorageReadEnable - one-cycle byte read request
//   TxData/TxValid    - transmit byte and its valid
//   TxReady           - transmit sink ready
//   Busy              - controller not idle
//   Error             - sticky timeout flag, cleared on arm
//   CtrlState         - current state encoding
module capture_readout_ctrl
   import capture_pkg::*;
#(
   parameter logic [7:0]  HEADER_BYTE    = DefaultHeaderByte,
   parameter bit          TRIGGER_RISING = 1'b1,
   parameter int unsigned HOLDOFF_CYCLES = 16,
   parameter int unsigned VALID_TIMEOUT  = 8
) (
   input  logic       ReadClock,
   input  logic       Reset,
   input  logic       ArmCmd,
   input  logic       AbortCmd,
   input  logic       ForceTrigger,
   input  logic       TriggerIn,
   input  logic [1:0] StorageState,
   input  logic       StorageDataReady,
   input  logic       StorageDataValid,
   input  logic [7:0] StorageData,
   output logic       WriteStrobe,
   output logic       StorageReadEnable,
   output logic [7:0] TxData,
   output logic       TxValid,
   input  logic       TxReady,
   output logic       Busy,
   output logic       Error,
   output logic [3:0] CtrlState
);

   // VALID_TIMEOUT is expected in 1..256.
   localparam logic [7:0] ValidLast  = 8'(VALID_TIMEOUT - 1);
   localparam logic [1:0] StrobeLast = 2'(StrobeAckCycles - 1);

   ctrl_state_e state_q, state_d;

   logic        arm_load;
   logic        trigger_accept;
   logic        tx_accept;
   logic        strobe_expired;
   logic        valid_expired;

   logic [1:0]  strobe_cnt_q;
   logic [7:0]  valid_cnt_q;
   logic [15:0] byte_cnt_q;
   logic [7:0]  tx_data_q;
   logic        error_q;
   logic        abort_q;

   assign arm_load  = (state_q == StIdle) && ArmCmd;
   assign tx_accept = TxValid && TxReady;

   // Abort in the same cycle takes priority, so no error is raised then.
   assign strobe_expired = (state_q == StStrobe) && (StorageState != StoreStoring) &&
                           (strobe_cnt_q == StrobeLast) && !AbortCmd;
   // Data arriving on the last allowed cycle wins over the timeout.
   assign valid_expired  = (state_q == StWaitValid) && !StorageDataValid &&
                           (valid_cnt_q == ValidLast);

   trigger_qualifier #(
      .TRIGGER_RISING (TRIGGER_RISING),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
   ) u_trigger_qualifier (
      .clk            (ReadClock),
      .rst            (Reset),
      .clear          (arm_load),
      .enable         (state_q == StArmed),
      .abort          (AbortCmd),
      .trigger_in     (TriggerIn),
      .force_trigger  (ForceTrigger),
      .store_state    (StorageState),
      .trigger_accept (trigger_accept)
   );

   // State register
   always_ff @(posedge ReadClock) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (ArmCmd) state_d = StArmed;
         end
         StArmed: begin
            if (AbortCmd) begin
               state_d = StIdle;
            end else if (trigger_accept) begin
               state_d = StStrobe;
            end
         end
         StStrobe: begin
            if (AbortCmd) begin
               state_d = StIdle;
            end else if (StorageState == StoreStoring) begin
               state_d = StCapture;
            end else if (strobe_expired) begin
               state_d = StArmed;
            end
         end
         StCapture: begin
            if (StorageState == StoreSending) state_d = StHeader;
         end
         StHeader: begin
            if (abort_q || TxReady) state_d = StRead;
         end
         StRead: begin
            if (StorageDataReady) begin
               state_d = StWaitValid;
            end else if (StorageState == StoreReady) begin
               state_d = abort_q ? StIdle : StTrailerHi;
            end
         end
         StWaitValid: begin
            if (StorageDataValid) begin
               // An aborted frame discards the byte instead of sending it.
               state_d = abort_q ? StRead : StSend;
            end else if (valid_expired) begin
               state_d = StRead;
            end
         end
         StSend: begin
            if (abort_q || TxReady) state_d = StRead;
         end
         StTrailerHi: begin
            if (abort_q) begin
               state_d = StIdle;
            end else if (TxReady) begin
               state_d = StTrailerLo;
            end
         end
         StTrailerLo: begin
            if (abort_q || TxReady) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Counters, captured byte and status flags
   always_ff @(posedge ReadClock) begin
      if (Reset) begin
         strobe_cnt_q <= '0;
         valid_cnt_q  <= '0;
         byte_cnt_q   <= '0;
         tx_data_q    <= '0;
         error_q      <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         // Both timers run from zero on every entry into their state.
         strobe_cnt_q <= (state_q == StStrobe) ? strobe_cnt_q + 2'd1 : '0;
         valid_cnt_q  <= (state_q == StWaitValid) ? valid_cnt_q + 8'd1 : '0;

         if ((state_q == StWaitValid) && StorageDataValid) begin
            tx_data_q <= StorageData;
         end

         if (arm_load) begin
            byte_cnt_q <= '0;
            error_q    <= 1'b0;
            abort_q    <= 1'b0;
         end else begin
            if (strobe_expired || valid_expired) begin
               error_q <= 1'b1;
            end
            if (AbortCmd && is_drain_state(state_q)) begin
               abort_q <= 1'b1;
            end
            if ((state_q == StSend) && tx_accept && (byte_cnt_q != 16'hFFFF)) begin
               byte_cnt_q <= byte_cnt_q + 16'd1;
            end
         end
      end
   end

   // Outputs
   always_comb begin
      WriteStrobe       = (state_q == StStrobe);
      StorageReadEnable = (state_q == StRead) && StorageDataReady;
      TxValid           = 1'b0;
      TxData            = 8'h00;
      case (state_q)
         StHeader: begin
            TxValid = !abort_q;
            TxData  = HEADER_BYTE;
         end
         StSend: begin
            TxValid = !abort_q;
            TxData  = tx_data_q;
         end
         StTrailerHi: begin
            TxValid = !abort_q;
            TxData  = byte_cnt_q[15:8];
         end
         StTrailerLo: begin
            TxValid = !abort_q;
            TxData  = byte_cnt_q[7:0];
         end
         default: ;
      endcase
      Busy      = (state_q != StIdle);
      Error     = error_q;
      CtrlState = state_q;
   end

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Directed testbench for capture_readout_ctrl with a small behavioural store.
module tb_capture_readout_ctrl;

   logic       clk;
   logic       Reset;
   logic       ArmCmd;
   logic       AbortCmd;
   logic       ForceTrigger;
   logic       TriggerIn;
   logic [1:0] StorageState;
   logic       StorageDataReady;
   logic       StorageDataValid;
   logic [7:0] StorageData;
   logic       WriteStrobe;
   logic       StorageReadEnable;
   logic [7:0] TxData;
   logic       TxValid;
   logic       TxReady;
   logic       Busy;
   logic       Error;
   logic [3:0] CtrlState;

   int passed = 0;
   int total  = 0;

   capture_readout_ctrl #(
      .HEADER_BYTE    (8'hA5),
      .TRIGGER_RISING (1'b1),
      .HOLDOFF_CYCLES (16),
      .VALID_TIMEOUT  (8)
   ) dut (
      .ReadClock         (clk),
      .Reset             (Reset),
      .ArmCmd            (ArmCmd),
      .AbortCmd          (AbortCmd),
      .ForceTrigger      (ForceTrigger),
      .TriggerIn         (TriggerIn),
      .StorageState      (StorageState),
      .StorageDataReady  (StorageDataReady),
      .StorageDataValid  (StorageDataValid),
      .StorageData       (StorageData),
      .WriteStrobe       (WriteStrobe),
      .StorageReadEnable (StorageReadEnable),
      .TxData            (TxData),
      .TxValid           (TxValid),
      .TxReady           (TxReady),
      .Busy              (Busy),
      .Error             (Error),
      .CtrlState         (CtrlState)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural capture store ----------------
   logic [7:0] mem [0:7];
   int         cap_n = 0;
   int         withhold_cfg = 0;
   logic [1:0] st_state;
   int         st_rd, st_cnt, st_timer, withhold_left;
   logic       ren_s, ws_s;

   assign StorageState     = st_state;
   assign StorageDataReady = (st_state == 2'b10) && (st_rd < st_cnt);

   always @(negedge clk) begin
      ren_s <= StorageReadEnable;
      ws_s  <= WriteStrobe;
   end

   always @(posedge clk) begin
      if (Reset) begin
         st_state         <= 2'b00;
         st_rd            <= 0;
         st_cnt           <= 0;
         st_timer         <= 0;
         withhold_left    <= 0;
         StorageDataValid <= 1'b0;
         StorageData      <= 8'h00;
      end else begin
         StorageDataValid <= 1'b0;
         case (st_state)
            2'b00: if (ws_s) begin
               st_state <= 2'b01;
               st_timer <= 0;
            end
            2'b01: if (st_timer == 3) begin
               st_state      <= 2'b10;
               st_cnt        <= cap_n;
               st_rd         <= 0;
               withhold_left <= withhold_cfg;
            end else begin
               st_timer <= st_timer + 1;
            end
            default: begin
               if (ren_s && (st_rd < st_cnt)) begin
                  if (withhold_left > 0) begin
                     withhold_left <= withhold_left - 1;
                  end else begin
                     StorageDataValid <= 1'b1;
                     StorageData      <= mem[st_rd[2:0]];
                     st_rd            <= st_rd + 1;
                  end
               end else if (st_rd >= st_cnt) begin
                  st_state <= 2'b00;
               end
            end
         endcase
      end
   end

   // ---------------- stream monitor ----------------
   int         rd_count = 0;
   int         tv_count = 0;
   int         stab_err = 0;
   logic       stall_q = 1'b0;
   logic [7:0] stall_data = 8'h00;
   logic [7:0] rx_q [$];

   always @(negedge clk) begin
      if (Reset) begin
         stall_q <= 1'b0;
      end else begin
         if (StorageReadEnable) rd_count <= rd_count + 1;
         if (TxValid) tv_count <= tv_count + 1;
         if (TxValid && TxReady) rx_q.push_back(TxData);
         if (stall_q && (!TxValid || (TxData != stall_data))) stab_err <= stab_err + 1;
         stall_q    <= TxValid && !TxReady;
         stall_data <= TxData;
      end
   end

   // ---------------- helpers (stimulus only) ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      Reset        = 1'b1;
      ArmCmd       = 1'b0;
      AbortCmd     = 1'b0;
      ForceTrigger = 1'b0;
      TriggerIn    = 1'b0;
      TxReady      = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   task automatic load_store(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int wh);
      mem[0] = b0;
      mem[1] = b1;
      mem[2] = b2;
      mem[3] = b3;
      cap_n        = n;
      withhold_cfg = wh;
   endtask

   task automatic start_capture;
      ArmCmd = 1'b1;
      tick();
      ArmCmd = 1'b0;
      repeat (18) tick();
      TriggerIn = 1'b1;
      tick();
      TriggerIn = 1'b0;
   endtask

   task automatic wait_idle(input bit bp, input int limit);
      for (int i = 0; i < limit && Busy; i++) begin
         tick();
         if (bp) TxReady = ~TxReady;
      end
      TxReady = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      do_reset();
      total++; if (CtrlState !== 4'd0) $display("FAIL rst_state got=%0d exp=0", CtrlState); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", Busy); else passed++;
      total++; if (WriteStrobe !== 1'b0) $display("FAIL rst_strobe got=%b exp=0", WriteStrobe); else passed++;
      total++; if (StorageReadEnable !== 1'b0) $display("FAIL rst_ren got=%b exp=0", StorageReadEnable); else passed++;
      total++; if (TxValid !== 1'b0) $display("FAIL rst_txvalid got=%b exp=0", TxValid); else passed++;
      total++; if (TxData !== 8'h00) $display("FAIL rst_txdata got=%h exp=00", TxData); else passed++;
      total++; if (Error !== 1'b0) $display("FAIL rst_error got=%b exp=0", Error); else passed++;
   endtask

   task automatic test_normal;
      logic [7:0] exp [7];
      logic [7:0] got;
      int rb, rd0;
      exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h04};
      do_reset();
      load_store(4, 8'h11, 8'h22, 8'h33, 8'h44, 0);
      rb  = rx_q.size();
      rd0 = rd_count;
      ArmCmd = 1'b1;
      tick();
      ArmCmd = 1'b0;
      total++; if (CtrlState !== 4'd1) $display("FAIL arm_state got=%0d exp=1", CtrlState); else passed++;
      total++; if (Busy !== 1'b1) $display("FAIL arm_busy got=%b exp=1", Busy); else passed++;
      repeat (17) tick();
      total++; if (CtrlState !== 4'd1) $display("FAIL armed_hold got=%0d exp=1", CtrlState); else passed++;
      TriggerIn = 1'b1;
      tick();
      TriggerIn = 1'b0;
      total++; if (WriteStrobe !== 1'b1) $display("FAIL trig_strobe got=%b exp=1", WriteStrobe); else passed++;
      total++; if (CtrlState !== 4'd2) $display("FAIL trig_state got=%0d exp=2", CtrlState); else passed++;
      wait_idle(1'b0, 300);
      total++; if (Busy !== 1'b0) $display("FAIL normal_done busy=%b exp=0", Busy); else passed++;
      total++; if (rx_q.size() - rb !== 7) $display("FAIL normal_len got=%0d exp=7", rx_q.size() - rb); else passed++;
      for (int i = 0; i < 7; i++) begin
         got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
         total++; if (got !== exp[i]) $display("FAIL normal_byte%0d got=%h exp=%h", i, got, exp[i]); else passed++;
      end
      total++; if (rd_count - rd0 !== 4) $display("FAIL normal_reads got=%0d exp=4", rd_count - rd0); else passed++;
      total++; if (Error !== 1'b0) $display("FAIL normal_error got=%b exp=0", Error); else passed++;
   endtask

   task automatic test_backpressure;
      logic [7:0] exp [7];
      logic [7:0] got;
      int rb, rd0, se0;
      exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h04};
      do_reset();
      load_store(4, 8'h11, 8'h22, 8'h33, 8'h44, 0);
      rb  = rx_q.size();
      rd0 = rd_count;
      se0 = stab_err;
      start_capture();
      wait_idle(1'b1, 400);
      total++; if (Busy !== 1'b0) $display("FAIL bp_done busy=%b exp=0", Busy); else passed++;
      total++; if (rx_q.size() - rb !== 7) $display("FAIL bp_len got=%0d exp=7", rx_q.size() - rb); else passed++;
      for (int i = 0; i < 7; i++) begin
         got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
         total++; if (got !== exp[i]) $display("FAIL bp_byte%0d got=%h exp=%h", i, got, exp[i]); else passed++;
      end
      total++; if (stab_err - se0 !== 0) $display("FAIL bp_stable violations=%0d exp=0", stab_err - se0); else passed++;
      total++; if (rd_count - rd0 !== 4) $display("FAIL bp_reads got=%0d exp=4", rd_count - rd0); else passed++;
   endtask

   task automatic test_holdoff;
      do_reset();
      load_store(0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      ArmCmd = 1'b1;
      tick();
      ArmCmd = 1'b0;
      repeat (4) tick();
      TriggerIn = 1'b1;
      tick();
      total++; if (WriteStrobe !== 1'b0) $display("FAIL holdoff_drop_strobe got=%b exp=0", WriteStrobe); else passed++;
      total++; if (CtrlState !== 4'd1) $display("FAIL holdoff_drop_state got=%0d exp=1", CtrlState); else passed++;
      repeat (13) tick();
      total++; if (CtrlState !== 4'd1) $display("FAIL holdoff_no_queue got=%0d exp=1", CtrlState); else passed++;
      tick();
      ForceTrigger = 1'b1;
      tick();
      ForceTrigger = 1'b0;
      total++; if (WriteStrobe !== 1'b1) $display("FAIL force_strobe got=%b exp=1", WriteStrobe); else passed++;
      AbortCmd = 1'b1;
      tick();
      AbortCmd  = 1'b0;
      TriggerIn = 1'b0;
      total++; if (CtrlState !== 4'd0) $display("FAIL strobe_abort_state got=%0d exp=0", CtrlState); else passed++;
      total++; if (WriteStrobe !== 1'b0) $display("FAIL strobe_abort_ws got=%b exp=0", WriteStrobe); else passed++;
   endtask

   task automatic test_abort;
      int rd0, tv0;
      do_reset();
      load_store(3, 8'h31, 8'h32, 8'h33, 8'h00, 0);
      rd0 = rd_count;
      tv0 = tv_count;
      start_capture();
      for (int i = 0; i < 20 && CtrlState != 4'd3; i++) tick();
      total++; if (CtrlState !== 4'd3) $display("FAIL abort_capture got=%0d exp=3", CtrlState); else passed++;
      AbortCmd = 1'b1;
      tick();
      AbortCmd = 1'b0;
      wait_idle(1'b0, 200);
      total++; if (Busy !== 1'b0) $display("FAIL abort_done busy=%b exp=0", Busy); else passed++;
      total++; if (rd_count - rd0 !== 3) $display("FAIL abort_reads got=%0d exp=3", rd_count - rd0); else passed++;
      total++; if (tv_count - tv0 !== 0) $display("FAIL abort_txvalid cycles=%0d exp=0", tv_count - tv0); else passed++;
      total++; if (Error !== 1'b0) $display("FAIL abort_error got=%b exp=0", Error); else passed++;
   endtask

   task automatic test_timeout;
      logic [7:0] exp [5];
      logic [7:0] got;
      int rb;
      exp = '{8'hA5, 8'h77, 8'h88, 8'h00, 8'h02};
      do_reset();
      load_store(2, 8'h77, 8'h88, 8'h00, 8'h00, 1);
      rb = rx_q.size();
      start_capture();
      for (int i = 0; i < 40 && CtrlState != 4'd6; i++) tick();
      total++; if (CtrlState !== 4'd6) $display("FAIL to_wait got=%0d exp=6", CtrlState); else passed++;
      repeat (7) tick();
      total++; if (CtrlState !== 4'd6) $display("FAIL to_still_wait got=%0d exp=6", CtrlState); else passed++;
      total++; if (Error !== 1'b0) $display("FAIL to_early_error got=%b exp=0", Error); else passed++;
      tick();
      total++; if (CtrlState !== 4'd5) $display("FAIL to_back_read got=%0d exp=5", CtrlState); else passed++;
      total++; if (Error !== 1'b1) $display("FAIL to_error_set got=%b exp=1", Error); else passed++;
      wait_idle(1'b0, 300);
      total++; if (Busy !== 1'b0) $display("FAIL to_done busy=%b exp=0", Busy); else passed++;
      total++; if (Error !== 1'b1) $display("FAIL to_error_sticky got=%b exp=1", Error); else passed++;
      for (int i = 0; i < 5; i++) begin
         got = (rb + i < rx_q.size()) ? rx_q[rb + i] : 8'hxx;
         total++; if (got !== exp[i]) $display("FAIL to_byte%0d got=%h exp=%h", i, got, exp[i]); else passed++;
      end
      ArmCmd = 1'b1;
      tick();
      ArmCmd = 1'b0;
      total++; if (Error !== 1'b0) $display("FAIL to_error_clear got=%b exp=0", Error); else passed++;
      AbortCmd = 1'b1;
      tick();
      AbortCmd = 1'b0;
      total++; if (CtrlState !== 4'd0) $display("FAIL to_abort_armed got=%0d exp=0", CtrlState); else passed++;
   endtask

   task automatic test_reset_mid;
      do_reset();
      load_store(4, 8'h11, 8'h22, 8'h33, 8'h44, 0);
      start_capture();
      for (int i = 0; i < 60 && CtrlState != 4'd7; i++) tick();
      TxReady = 1'b0;
      total++; if (CtrlState !== 4'd7) $display("FAIL rm_in_send got=%0d exp=7", CtrlState); else passed++;
      total++; if (TxValid !== 1'b1) $display("FAIL rm_txvalid_pre got=%b exp=1", TxValid); else passed++;
      Reset = 1'b1;
      tick();
      total++; if (TxValid !== 1'b0) $display("FAIL rm_txvalid got=%b exp=0", TxValid); else passed++;
      total++; if (Busy !== 1'b0) $display("FAIL rm_busy got=%b exp=0", Busy); else passed++;
      total++; if (CtrlState !== 4'd0) $display("FAIL rm_state got=%0d exp=0", CtrlState); else passed++;
      total++; if (TxData !== 8'h00) $display("FAIL rm_txdata got=%h exp=00", TxData); else passed++;
      Reset   = 1'b0;
      TxReady = 1'b1;
      tick();
   endtask

   initial begin
      Reset        = 1'b1;
      ArmCmd       = 1'b0;
      AbortCmd     = 1'b0;
      ForceTrigger = 1'b0;
      TriggerIn    = 1'b0;
      TxReady      = 1'b1;
      test_reset();
      test_normal();
      test_backpressure();
      test_holdoff();
      test_abort();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
      $fatal(1, "watchdog");
   end

endmodule
